// File: rtl/noc_async_fifo_link.sv
// noc_async_fifo_link
//
// NoC-side endpoint of a split asynchronous FIFO pair between a NoC router
// and a memory domain clocked independently.
//   * NoC->domain (TX): storage lives here. The router writes packets. The
//     domain reads entries through noc_fifo_tx_data_o, addressed by its own
//     Gray read pointer. It learns how full the FIFO is from
//     noc_fifo_tx_waddr_o.
//   * domain->NoC (RX): storage lives in the domain. This block publishes a
//     Gray read pointer and pops entries presented on noc_fifo_rx_data_i
//     into a registered output stage.
//
// Configuration macro: NOC_ASYNC_FIFO_SYNC3_EN selects 3-flop pointer
// synchronizers. When it is undefined, the synchronizers use 2 flops.
//
// Ports:
//   clk_i, reset_n_i        NoC clock, asynchronous active-low reset
//   tx_data_i/valid/ready   router -> domain packet stream
//   rx_data_o/valid/ready   domain -> router packet stream (registered)
//   noc_fifo_tx_data_o      local TX entry selected by remote read pointer
//   noc_fifo_tx_raddr_i     remote Gray read pointer (asynchronous)
//   noc_fifo_tx_waddr_o     local Gray write pointer (registered)
//   noc_fifo_rx_data_i      remote RX entry at noc_fifo_rx_raddr_o
//   noc_fifo_rx_raddr_o     local Gray read pointer (registered)
//   noc_fifo_rx_waddr_i     remote Gray write pointer (asynchronous)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised, it stays high and data stays stable
// until that transfer happens. Neither tx_ready_o nor rx_valid_o depends
// combinationally on the other side of its handshake.
module noc_async_fifo_link #(
  parameter int NOC_ASYNC_FIFO_PACKET_SIZE = 140,
  parameter int NOC_ASYNC_FIFO_AWIDTH      = 3
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] tx_data_i,
  input  logic                                  tx_valid_i,
  output logic                                  tx_ready_o,
  output logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] rx_data_o,
  output logic                                  rx_valid_o,
  input  logic                                  rx_ready_i,
  output logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] noc_fifo_tx_data_o,
  input  logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_tx_raddr_i,
  output logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_tx_waddr_o,
  input  logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] noc_fifo_rx_data_i,
  output logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_rx_raddr_o,
  input  logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_rx_waddr_i
);

  localparam int PW    = NOC_ASYNC_FIFO_PACKET_SIZE;
  localparam int AW    = NOC_ASYNC_FIFO_AWIDTH;
  localparam int PTR_W = AW + 1;
  localparam int DEPTH = 1 << AW;
`ifdef NOC_ASYNC_FIFO_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Gray write pointer value that means "full" for a given read pointer.
  // The top two bits are inverted, which also covers pointer wrap.
  function automatic logic [PTR_W-1:0] full_ptr(input logic [PTR_W-1:0] rg);
    return {~rg[AW:AW-1], rg[AW-2:0]};
  endfunction

  // ---------------- pointer synchronizers ----------------
  logic [PTR_W-1:0] rsync_q [SYNC_N];
  logic [PTR_W-1:0] wsync_q [SYNC_N];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < SYNC_N; i++) begin
        rsync_q[i] <= '0;
        wsync_q[i] <= '0;
      end
    end else begin
      rsync_q[0] <= noc_fifo_tx_raddr_i;
      wsync_q[0] <= noc_fifo_rx_waddr_i;
      for (int i = 1; i < SYNC_N; i++) begin
        rsync_q[i] <= rsync_q[i-1];
        wsync_q[i] <= wsync_q[i-1];
      end
    end
  end

  // ---------------- TX write side ----------------
  logic [PW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wbin_q, wgray_q;
  logic [PTR_W-1:0] wbin_next, wgray_next, tx_rbin;
  logic             tx_ready_q, wr_en;

  assign wr_en      = tx_valid_i & tx_ready_q;
  assign wbin_next  = wr_en ? wbin_q + 1'b1 : wbin_q;
  assign wgray_next = bin2gray(wbin_next);

  // Ready is registered. It uses the new write pointer, so it falls right
  // after the filling write. It uses the pre-edge synchronized read
  // pointer, so release takes one extra cycle. A stale read pointer can
  // only make full look longer, never shorter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      wbin_q     <= wbin_next;
      wgray_q    <= wgray_next;
      tx_ready_q <= ~(wgray_next == full_ptr(rsync_q[SYNC_N-1]));
    end
  end

  // The storage has no reset. The remote side reads an entry only after
  // its write pointer has been synchronized over there.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wbin_q[AW-1:0]] <= tx_data_i;
    end
  end

  assign tx_rbin             = gray2bin(noc_fifo_tx_raddr_i);
  assign noc_fifo_tx_data_o  = mem[tx_rbin[AW-1:0]];
  assign noc_fifo_tx_waddr_o = wgray_q;
  assign tx_ready_o          = tx_ready_q;

  // ---------------- RX read side ----------------
  logic [PTR_W-1:0] rbin_q, rgray_q;
  logic [PW-1:0]    rx_data_q;
  logic             rx_valid_q, empty, pop;

  assign empty = (rgray_q == wsync_q[SYNC_N-1]);
  assign pop   = ~empty & (~rx_valid_q | rx_ready_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rbin_q     <= '0;
      rgray_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (pop) begin
      rx_data_q  <= noc_fifo_rx_data_i;
      rx_valid_q <= 1'b1;
      rbin_q     <= rbin_q + 1'b1;
      rgray_q    <= bin2gray(rbin_q + 1'b1);
    end else if (rx_ready_i) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign rx_data_o           = rx_data_q;
  assign rx_valid_o          = rx_valid_q;
  assign noc_fifo_rx_raddr_o = rgray_q;

endmodule
